// File: rtl/ast_dmx_route_pkg.sv
// Shared types for the Avalon-ST direction demultiplexer.
package ast_dmx_package;

    // Packet-level routing state
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FWD  = 2'd1,
        ST_DROP = 2'd2
    } dmx_state_e;

    // Source of the direction selector
    typedef enum logic {
        ROUTE_BY_DIR     = 1'b0,
        ROUTE_BY_CHANNEL = 1'b1
    } route_mode_e;

    // Scenario identifiers used by verification collateral
    typedef enum logic [2:0] {
        TC_RESET,
        TC_FWD,
        TC_DROP,
        TC_STALL,
        TC_BACK_TO_BACK,
        TC_RESET_MID,
        TC_DROP_SAT,
        TC_RANDOM
    } test_case_e;

endpackage

// File: rtl/ast_dmx_route_out_reg.sv
// One-entry output register stage for a single demux direction.
module ast_dmx_out_reg
    import ast_dmx_package::*;
#(
    parameter int DATA_WIDTH    = 64,
    parameter int CHANNEL_WIDTH = 8,
    parameter int EMPTY_WIDTH   = 3
) (
    input  logic                     clk_i,
    input  logic                     arst_n_i,
    input  logic                     load_i,
    input  logic [DATA_WIDTH-1:0]    data_i,
    input  logic                     sop_i,
    input  logic                     eop_i,
    input  logic [EMPTY_WIDTH-1:0]   empty_i,
    input  logic [CHANNEL_WIDTH-1:0] channel_i,
    input  logic                     ready_i,
    output logic                     valid_o,
    output logic [DATA_WIDTH-1:0]    data_o,
    output logic                     sop_o,
    output logic                     eop_o,
    output logic [EMPTY_WIDTH-1:0]   empty_o,
    output logic [CHANNEL_WIDTH-1:0] channel_o
);

    logic                     valid_q, valid_d;
    logic [DATA_WIDTH-1:0]    data_q, data_d;
    logic                     sop_q, sop_d;
    logic                     eop_q, eop_d;
    logic [EMPTY_WIDTH-1:0]   empty_q, empty_d;
    logic [CHANNEL_WIDTH-1:0] channel_q, channel_d;

    // Capture a new beat on load; otherwise hold until downstream takes it
    always_comb begin
        valid_d   = valid_q;
        data_d    = data_q;
        sop_d     = sop_q;
        eop_d     = eop_q;
        empty_d   = empty_q;
        channel_d = channel_q;
        if (load_i) begin
            valid_d   = 1'b1;
            data_d    = data_i;
            sop_d     = sop_i;
            eop_d     = eop_i;
            empty_d   = empty_i;
            channel_d = channel_i;
        end else if (ready_i) begin
            valid_d   = 1'b0;
        end
    end

    // Stage register, fully cleared by reset
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            valid_q   <= 1'b0;
            data_q    <= '0;
            sop_q     <= 1'b0;
            eop_q     <= 1'b0;
            empty_q   <= '0;
            channel_q <= '0;
        end else begin
            valid_q   <= valid_d;
            data_q    <= data_d;
            sop_q     <= sop_d;
            eop_q     <= eop_d;
            empty_q   <= empty_d;
            channel_q <= channel_d;
        end
    end

    assign valid_o   = valid_q;
    assign data_o    = data_q;
    assign sop_o     = sop_q;
    assign eop_o     = eop_q;
    assign empty_o   = empty_q;
    assign channel_o = channel_q;

endmodule

// File: rtl/ast_dmx_route.sv
// Avalon-ST demux: routes whole packets to one of TX_DIR outputs or drops them.
module ast_dmx_route
    import ast_dmx_package::*;
#(
    parameter int DATA_WIDTH     = 64,
    parameter int CHANNEL_WIDTH  = 8,
    parameter int EMPTY_WIDTH    = $clog2(DATA_WIDTH/8),
    parameter int TX_DIR         = 4,
    parameter int DIR_SEL_WIDTH  = (TX_DIR == 1) ? 1 : $clog2(TX_DIR),
    parameter int ROUTE_MODE     = 0,
    parameter int DROP_CNT_WIDTH = 16
) (
    input  logic                      clk_i,
    input  logic                      arst_n_i,
    input  logic [DIR_SEL_WIDTH-1:0]  dir_i,
    input  logic [DATA_WIDTH-1:0]     ast_data_i,
    input  logic                      ast_startofpacket_i,
    input  logic                      ast_endofpacket_i,
    input  logic                      ast_valid_i,
    input  logic [EMPTY_WIDTH-1:0]    ast_empty_i,
    input  logic [CHANNEL_WIDTH-1:0]  ast_channel_i,
    output logic                      ast_ready_o,
    output logic [DATA_WIDTH-1:0]     ast_data_o          [TX_DIR-1:0],
    output logic                      ast_startofpacket_o [TX_DIR-1:0],
    output logic                      ast_endofpacket_o   [TX_DIR-1:0],
    output logic                      ast_valid_o         [TX_DIR-1:0],
    output logic [EMPTY_WIDTH-1:0]    ast_empty_o         [TX_DIR-1:0],
    output logic [CHANNEL_WIDTH-1:0]  ast_channel_o       [TX_DIR-1:0],
    input  logic                      ast_ready_i         [TX_DIR-1:0],
    output logic [DROP_CNT_WIDTH-1:0] drop_cnt_o
);

    localparam bit USE_CHANNEL = (ROUTE_MODE == int'(ROUTE_BY_CHANNEL));
    // Selector space is padded to a power of two so any selector value indexes safely
    localparam int SEL_SPAN = 2**DIR_SEL_WIDTH;
    localparam logic [DIR_SEL_WIDTH:0] TX_DIR_LIM = TX_DIR[DIR_SEL_WIDTH:0];

    dmx_state_e                state_q, state_d;
    logic [DIR_SEL_WIDTH-1:0]  cur_dir_q, cur_dir_d;
    logic [DROP_CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;

    logic [DIR_SEL_WIDTH-1:0]  sel;
    logic                      sel_in_range;
    logic [SEL_SPAN-1:0]       stage_free;
    logic                      accept;
    logic                      route_en;
    logic [DIR_SEL_WIDTH-1:0]  route_dir;
    logic                      drop_sop;
    logic [TX_DIR-1:0]         load;

    assign sel          = USE_CHANNEL ? ast_channel_i[DIR_SEL_WIDTH-1:0] : dir_i;
    assign sel_in_range = ({1'b0, sel} < TX_DIR_LIM);
    assign accept       = ast_valid_i && ast_ready_o;

    // Per-direction "can take a beat this cycle"; out-of-range selectors read as free
    always_comb begin
        stage_free = '1;
        for (int d = 0; d < TX_DIR; d++) begin
            stage_free[d] = !ast_valid_o[d] || ast_ready_i[d];
        end
    end

    // Sink ready follows the stage the current beat would land in; dropping never stalls
    always_comb begin
        ast_ready_o = 1'b0;
        if (arst_n_i) begin
            case (state_q)
                ST_IDLE: ast_ready_o = stage_free[sel];
                ST_FWD:  ast_ready_o = stage_free[cur_dir_q];
                ST_DROP: ast_ready_o = 1'b1;
                default: ast_ready_o = 1'b0;
            endcase
        end
    end

    // Packet FSM: pick direction on SOP, forward or drop until EOP
    always_comb begin
        state_d    = state_q;
        cur_dir_d  = cur_dir_q;
        drop_cnt_d = drop_cnt_q;
        route_en   = 1'b0;
        route_dir  = cur_dir_q;
        drop_sop   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Non-SOP beats in IDLE are consumed and discarded
                if (accept && ast_startofpacket_i) begin
                    if (sel_in_range) begin
                        route_en  = 1'b1;
                        route_dir = sel;
                        cur_dir_d = sel;
                        if (!ast_endofpacket_i) state_d = ST_FWD;
                    end else begin
                        drop_sop = 1'b1;
                        if (!ast_endofpacket_i) state_d = ST_DROP;
                    end
                end
            end
            ST_FWD: begin
                // Mid-packet SOP is plain data; direction stays locked
                if (accept) begin
                    route_en = 1'b1;
                    if (ast_endofpacket_i) state_d = ST_IDLE;
                end
            end
            ST_DROP: begin
                if (accept && ast_endofpacket_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (drop_sop && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + 1'b1;
        end
    end

    // Decode the routed beat into a per-direction load strobe
    always_comb begin
        load = '0;
        for (int d = 0; d < TX_DIR; d++) begin
            load[d] = route_en && (route_dir == DIR_SEL_WIDTH'(d));
        end
    end

    // Control state registers
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q    <= ST_IDLE;
            cur_dir_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            cur_dir_q  <= cur_dir_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt_o = drop_cnt_q;

    for (genvar g = 0; g < TX_DIR; g++) begin : g_out
        ast_dmx_out_reg #(
            .DATA_WIDTH    (DATA_WIDTH),
            .CHANNEL_WIDTH (CHANNEL_WIDTH),
            .EMPTY_WIDTH   (EMPTY_WIDTH)
        ) u_out_reg (
            .clk_i     (clk_i),
            .arst_n_i  (arst_n_i),
            .load_i    (load[g]),
            .data_i    (ast_data_i),
            .sop_i     (ast_startofpacket_i),
            .eop_i     (ast_endofpacket_i),
            .empty_i   (ast_empty_i),
            .channel_i (ast_channel_i),
            .ready_i   (ast_ready_i[g]),
            .valid_o   (ast_valid_o[g]),
            .data_o    (ast_data_o[g]),
            .sop_o     (ast_startofpacket_o[g]),
            .eop_o     (ast_endofpacket_o[g]),
            .empty_o   (ast_empty_o[g]),
            .channel_o (ast_channel_o[g])
        );
    end

endmodule

// File: tb/tb_ast_dmx_route.sv
// Bench for ast_dmx_route: directed scenarios on two configurations plus a
// randomized packet run against a queue-based reference model.
module tb_ast_dmx_route;

    typedef logic [43:0] beat_t;   // {data32, sop, eop, empty2, chan8}

    int tests  = 0;
    int failed = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: 4 directions, selector from dir_i
    logic        rst_a_n;
    logic [1:0]  a_dir;
    logic [63:0] a_data;
    logic        a_sop, a_eop, a_valid;
    logic [2:0]  a_empty;
    logic [7:0]  a_chan;
    logic        a_ready_o;
    logic [63:0] a_data_o  [3:0];
    logic        a_sop_o   [3:0];
    logic        a_eop_o   [3:0];
    logic        a_vld_o   [3:0];
    logic [2:0]  a_empty_o [3:0];
    logic [7:0]  a_chan_o  [3:0];
    logic        a_rdy_i   [3:0];
    logic [15:0] a_drop;

    // Instance B: 3 directions, selector from channel, 2-bit drop counter
    logic        rst_b_n;
    logic [1:0]  b_dir;
    logic [31:0] b_data;
    logic        b_sop, b_eop, b_valid;
    logic [1:0]  b_empty;
    logic [7:0]  b_chan;
    logic        b_ready_o;
    logic [31:0] b_data_o  [2:0];
    logic        b_sop_o   [2:0];
    logic        b_eop_o   [2:0];
    logic        b_vld_o   [2:0];
    logic [1:0]  b_empty_o [2:0];
    logic [7:0]  b_chan_o  [2:0];
    logic        b_rdy_i   [2:0];
    logic [1:0]  b_drop;

    beat_t exp_q [3][$];

    ast_dmx_route #(.DATA_WIDTH(64), .CHANNEL_WIDTH(8), .TX_DIR(4), .ROUTE_MODE(0), .DROP_CNT_WIDTH(16)) dut_a (
        .clk_i(clk), .arst_n_i(rst_a_n), .dir_i(a_dir),
        .ast_data_i(a_data), .ast_startofpacket_i(a_sop), .ast_endofpacket_i(a_eop),
        .ast_valid_i(a_valid), .ast_empty_i(a_empty), .ast_channel_i(a_chan),
        .ast_ready_o(a_ready_o),
        .ast_data_o(a_data_o), .ast_startofpacket_o(a_sop_o), .ast_endofpacket_o(a_eop_o),
        .ast_valid_o(a_vld_o), .ast_empty_o(a_empty_o), .ast_channel_o(a_chan_o),
        .ast_ready_i(a_rdy_i), .drop_cnt_o(a_drop)
    );

    ast_dmx_route #(.DATA_WIDTH(32), .CHANNEL_WIDTH(8), .TX_DIR(3), .ROUTE_MODE(1), .DROP_CNT_WIDTH(2)) dut_b (
        .clk_i(clk), .arst_n_i(rst_b_n), .dir_i(b_dir),
        .ast_data_i(b_data), .ast_startofpacket_i(b_sop), .ast_endofpacket_i(b_eop),
        .ast_valid_i(b_valid), .ast_empty_i(b_empty), .ast_channel_i(b_chan),
        .ast_ready_o(b_ready_o),
        .ast_data_o(b_data_o), .ast_startofpacket_o(b_sop_o), .ast_endofpacket_o(b_eop_o),
        .ast_valid_o(b_vld_o), .ast_empty_o(b_empty_o), .ast_channel_o(b_chan_o),
        .ast_ready_i(b_rdy_i), .drop_cnt_o(b_drop)
    );

    // Present one beat on A from a negedge and return at the negedge after it is accepted
    task automatic a_beat(input logic [1:0] dir, input logic [63:0] data, input logic sop,
                          input logic eop, input logic [2:0] emp, output int waits);
        logic rdy;
        a_dir = dir; a_data = data; a_sop = sop; a_eop = eop; a_empty = emp; a_valid = 1'b1;
        waits = 0;
        forever begin
            #1;
            rdy = a_ready_o;
            @(negedge clk);
            if (rdy) break;
            waits++;
            if (waits >= 50) begin
                tests++; failed++;
                $display("FAIL a_accept_timeout: ready_o=%0b after %0d cycles, want 1", rdy, waits);
                waits = -1;
                break;
            end
        end
        a_valid = 1'b0;
    endtask

    // Same for B, whose selector comes from the channel field
    task automatic b_beat(input logic [7:0] ch, input logic [31:0] data, input logic sop,
                          input logic eop, input logic [1:0] emp, output int waits);
        logic rdy;
        b_chan = ch; b_data = data; b_sop = sop; b_eop = eop; b_empty = emp; b_valid = 1'b1;
        waits = 0;
        forever begin
            #1;
            rdy = b_ready_o;
            @(negedge clk);
            if (rdy) break;
            waits++;
            if (waits >= 50) begin
                tests++; failed++;
                $display("FAIL b_accept_timeout: ready_o=%0b after %0d cycles, want 1", rdy, waits);
                waits = -1;
                break;
            end
        end
        b_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_a_n = 1'b0; rst_b_n = 1'b0;
        a_valid = 1'b1; b_valid = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        tests++; if (a_ready_o !== 1'b0) begin failed++; $display("FAIL reset_a_ready: got %0b want 0", a_ready_o); end
        tests++; if (b_ready_o !== 1'b0) begin failed++; $display("FAIL reset_b_ready: got %0b want 0", b_ready_o); end
        for (int d = 0; d < 4; d++) begin
            tests++; if (a_vld_o[d] !== 1'b0 || a_data_o[d] !== 64'h0) begin
                failed++; $display("FAIL reset_a_out%0d: got vld=%0b data=%h want 0/0", d, a_vld_o[d], a_data_o[d]);
            end
        end
        tests++; if (a_drop !== 16'd0) begin failed++; $display("FAIL reset_a_drop: got %0d want 0", a_drop); end
        tests++; if (b_drop !== 2'd0) begin failed++; $display("FAIL reset_b_drop: got %0d want 0", b_drop); end
        @(negedge clk);
        rst_a_n = 1'b1; rst_b_n = 1'b1; a_valid = 1'b0; b_valid = 1'b0;
        @(negedge clk);
        #1;
        tests++; if (a_ready_o !== 1'b1) begin failed++; $display("FAIL reset_release_ready: got %0b want 1", a_ready_o); end
        @(negedge clk);
    endtask

    task automatic test_fwd_3beat();
        int w;
        logic [63:0] d [3];
        for (int i = 0; i < 3; i++) d[i] = {$urandom, $urandom};
        for (int i = 0; i < 3; i++) begin
            a_beat(2'd2, d[i], i == 0, i == 2, 3'(i), w);
            tests++; if (w !== 0) begin failed++; $display("FAIL fwd_wait%0d: got %0d stall cycles want 0", i, w); end
            tests++;
            if (a_vld_o[2] !== 1'b1 || a_data_o[2] !== d[i] || a_sop_o[2] !== (i == 0) ||
                a_eop_o[2] !== (i == 2) || a_empty_o[2] !== 3'(i) || a_chan_o[2] !== 8'hA5) begin
                failed++;
                $display("FAIL fwd_beat%0d: got vld=%0b data=%h sop=%0b eop=%0b emp=%0d ch=%h want 1/%h/%0b/%0b/%0d/a5",
                         i, a_vld_o[2], a_data_o[2], a_sop_o[2], a_eop_o[2], a_empty_o[2], a_chan_o[2],
                         d[i], i == 0, i == 2, i);
            end
            tests++; if (a_vld_o[0] || a_vld_o[1] || a_vld_o[3]) begin
                failed++; $display("FAIL fwd_others%0d: got vld0/1/3=%0b%0b%0b want 000", i, a_vld_o[0], a_vld_o[1], a_vld_o[3]);
            end
        end
        @(negedge clk);
        tests++; if (a_vld_o[2] !== 1'b0) begin failed++; $display("FAIL fwd_drain: got vld=%0b want 0", a_vld_o[2]); end
    endtask

    task automatic test_drop_mode1();
        int w;
        tests++; if (b_drop !== 2'd0) begin failed++; $display("FAIL drop_pre: got %0d want 0", b_drop); end
        for (int i = 0; i < 3; i++) begin
            b_beat(8'h07, $urandom, i == 0, i == 2, 2'd0, w);
            tests++; if (w !== 0) begin failed++; $display("FAIL drop_ready%0d: got %0d stall cycles want 0", i, w); end
            tests++; if (b_vld_o[0] || b_vld_o[1] || b_vld_o[2]) begin
                failed++; $display("FAIL drop_out%0d: got vld=%0b%0b%0b want 000", i, b_vld_o[2], b_vld_o[1], b_vld_o[0]);
            end
            tests++; if (b_drop !== 2'd1) begin failed++; $display("FAIL drop_cnt%0d: got %0d want 1", i, b_drop); end
        end
    endtask

    task automatic test_stall();
        int w;
        logic [63:0] d0, d1, e0, e1, f0, g0;
        d0 = {$urandom, $urandom}; d1 = {$urandom, $urandom};
        e0 = {$urandom, $urandom}; e1 = {$urandom, $urandom};
        f0 = {$urandom, $urandom}; g0 = {$urandom, $urandom};
        a_rdy_i[1] = 1'b0;
        a_beat(2'd1, d0, 1'b1, 1'b0, 3'd0, w);
        tests++; if (w !== 0 || a_vld_o[1] !== 1'b1 || a_data_o[1] !== d0) begin
            failed++; $display("FAIL stall_first: got wait=%0d vld=%0b data=%h want 0/1/%h", w, a_vld_o[1], a_data_o[1], d0);
        end
        a_dir = 2'd1; a_data = d1; a_sop = 1'b0; a_eop = 1'b1; a_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            tests++; if (a_ready_o !== 1'b0) begin failed++; $display("FAIL stall_ready%0d: got %0b want 0", c, a_ready_o); end
            tests++; if (a_vld_o[1] !== 1'b1 || a_data_o[1] !== d0 || a_sop_o[1] !== 1'b1) begin
                failed++; $display("FAIL stall_hold%0d: got vld=%0b data=%h want 1/%h", c, a_vld_o[1], a_data_o[1], d0);
            end
            @(negedge clk);
        end
        a_rdy_i[1] = 1'b1;
        a_beat(2'd1, d1, 1'b0, 1'b1, 3'd5, w);
        tests++; if (w !== 0 || a_vld_o[1] !== 1'b1 || a_data_o[1] !== d1 || a_eop_o[1] !== 1'b1) begin
            failed++; $display("FAIL stall_release: got wait=%0d vld=%0b data=%h eop=%0b want 0/1/%h/1", w, a_vld_o[1], a_data_o[1], a_eop_o[1], d1);
        end
        a_beat(2'd0, e0, 1'b1, 1'b0, 3'd0, w);
        tests++; if (w !== 0 || a_vld_o[0] !== 1'b1 || a_data_o[0] !== e0) begin
            failed++; $display("FAIL stall_next0: got wait=%0d vld=%0b data=%h want 0/1/%h", w, a_vld_o[0], a_data_o[0], e0);
        end
        a_beat(2'd0, e1, 1'b0, 1'b1, 3'd1, w);
        tests++; if (w !== 0 || a_vld_o[0] !== 1'b1 || a_data_o[0] !== e1) begin
            failed++; $display("FAIL stall_next1: got wait=%0d vld=%0b data=%h want 0/1/%h", w, a_vld_o[0], a_data_o[0], e1);
        end
        // A parked beat on port 1 must not hold back traffic to port 0
        a_rdy_i[1] = 1'b0;
        a_beat(2'd1, f0, 1'b1, 1'b1, 3'd0, w);
        a_beat(2'd0, g0, 1'b1, 1'b1, 3'd0, w);
        tests++; if (w !== 0 || a_data_o[0] !== g0 || a_vld_o[0] !== 1'b1 || a_vld_o[1] !== 1'b1 || a_data_o[1] !== f0) begin
            failed++; $display("FAIL stall_bypass: got wait=%0d d0=%h d1=%h v0=%0b v1=%0b want 0/%h/%h/1/1",
                                w, a_data_o[0], a_data_o[1], a_vld_o[0], a_vld_o[1], g0, f0);
        end
        a_rdy_i[1] = 1'b1;
        @(negedge clk);
        tests++; if (a_vld_o[1] !== 1'b0 || a_vld_o[0] !== 1'b0) begin
            failed++; $display("FAIL stall_drain: got v0=%0b v1=%0b want 0/0", a_vld_o[0], a_vld_o[1]);
        end
    endtask

    task automatic test_back_to_back();
        int w;
        logic [1:0] dir;
        logic [63:0] d;
        for (int i = 0; i < 8; i++) begin
            dir = (i % 2 == 1) ? 2'd3 : 2'd0;
            d = {$urandom, $urandom};
            a_beat(dir, d, 1'b1, 1'b1, 3'(i), w);
            tests++;
            if (w !== 0 || a_vld_o[dir] !== 1'b1 || a_data_o[dir] !== d || a_sop_o[dir] !== 1'b1 ||
                a_eop_o[dir] !== 1'b1 || a_vld_o[dir ^ 2'd3] !== 1'b0) begin
                failed++;
                $display("FAIL b2b_%0d: got wait=%0d vld=%0b data=%h sop=%0b eop=%0b other=%0b want 0/1/%h/1/1/0",
                         i, w, a_vld_o[dir], a_data_o[dir], a_sop_o[dir], a_eop_o[dir], a_vld_o[dir ^ 2'd3], d);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int w;
        logic [63:0] p0, p1;
        p0 = {$urandom, $urandom}; p1 = {$urandom, $urandom};
        a_beat(2'd2, 64'h1111, 1'b1, 1'b0, 3'd0, w);
        a_beat(2'd2, 64'h2222, 1'b0, 1'b0, 3'd0, w);
        a_dir = 2'd2; a_data = 64'h3333; a_sop = 1'b0; a_eop = 1'b0; a_valid = 1'b1;
        rst_a_n = 1'b0;
        #1;
        tests++;
        if (a_vld_o[0] || a_vld_o[1] || a_vld_o[2] || a_vld_o[3] || a_data_o[2] !== 64'h0 || a_ready_o !== 1'b0) begin
            failed++; $display("FAIL rmid_clear: got v2=%0b d2=%h ready=%0b want 0/0/0", a_vld_o[2], a_data_o[2], a_ready_o);
        end
        @(negedge clk);
        rst_a_n = 1'b1; a_valid = 1'b0;
        @(negedge clk);
        a_beat(2'd1, 64'hBAD0, 1'b0, 1'b0, 3'd0, w);
        tests++; if (a_vld_o[0] || a_vld_o[1] || a_vld_o[2] || a_vld_o[3]) begin
            failed++; $display("FAIL rmid_stray: got vld=%0b%0b%0b%0b want 0000", a_vld_o[3], a_vld_o[2], a_vld_o[1], a_vld_o[0]);
        end
        a_beat(2'd1, p0, 1'b1, 1'b0, 3'd0, w);
        tests++; if (a_vld_o[1] !== 1'b1 || a_data_o[1] !== p0 || a_sop_o[1] !== 1'b1) begin
            failed++; $display("FAIL rmid_p0: got vld=%0b data=%h sop=%0b want 1/%h/1", a_vld_o[1], a_data_o[1], a_sop_o[1], p0);
        end
        a_beat(2'd1, p1, 1'b0, 1'b1, 3'd2, w);
        tests++; if (a_vld_o[1] !== 1'b1 || a_data_o[1] !== p1 || a_eop_o[1] !== 1'b1 || a_vld_o[2] !== 1'b0) begin
            failed++; $display("FAIL rmid_p1: got vld=%0b data=%h eop=%0b v2=%0b want 1/%h/1/0", a_vld_o[1], a_data_o[1], a_eop_o[1], a_vld_o[2], p1);
        end
        @(negedge clk);
    endtask

    task automatic test_drop_sat();
        int w, expv;
        rst_b_n = 1'b0;
        @(negedge clk);
        rst_b_n = 1'b1;
        @(negedge clk);
        for (int i = 1; i <= 5; i++) begin
            b_beat(8'(($urandom_range(0, 63) << 2) | 3), $urandom, 1'b1, 1'b1, 2'd0, w);
            expv = (i > 3) ? 3 : i;
            tests++; if (b_drop !== 2'(expv)) begin failed++; $display("FAIL drop_sat%0d: got %0d want %0d", i, b_drop, expv); end
        end
    endtask

    task automatic test_random();
        bit done;
        int drops;
        done = 1'b0;
        drops = 0;
        rst_b_n = 1'b0;
        @(negedge clk);
        rst_b_n = 1'b1;
        @(negedge clk);
        fork
            begin : drive
                int w, len, sel;
                logic [7:0] ch, bch;
                logic [31:0] d;
                logic sop, eop;
                logic [1:0] emp;
                for (int p = 0; p < 40; p++) begin
                    if ($urandom_range(0, 5) == 0) begin
                        b_beat(8'($urandom), $urandom, 1'b0, 1'($urandom), 2'd0, w);
                    end
                    ch  = 8'($urandom);
                    sel = int'(ch[1:0]);
                    len = $urandom_range(1, 4);
                    for (int b = 0; b < len; b++) begin
                        bch = (b == 0) ? ch : 8'($urandom);
                        d   = $urandom;
                        sop = (b == 0) ? 1'b1 : ($urandom_range(0, 7) == 0);
                        eop = (b == len - 1);
                        emp = eop ? 2'($urandom) : 2'd0;
                        b_beat(bch, d, sop, eop, emp, w);
                        if (w >= 0 && sel < 3) exp_q[sel].push_back({d, sop, eop, emp, bch});
                    end
                    if (sel == 3) drops++;
                end
                repeat (60) @(negedge clk);
                done = 1'b1;
            end
            begin : ready_gen
                while (!done) begin
                    @(negedge clk);
                    for (int d = 0; d < 3; d++) b_rdy_i[d] = ($urandom_range(0, 3) != 0);
                end
            end
            begin : monitor
                beat_t got, want;
                while (!done) begin
                    @(negedge clk);
                    #2;
                    for (int d = 0; d < 3; d++) begin
                        if (b_vld_o[d] && b_rdy_i[d]) begin
                            got = {b_data_o[d], b_sop_o[d], b_eop_o[d], b_empty_o[d], b_chan_o[d]};
                            tests++;
                            if (exp_q[d].size() == 0) begin
                                failed++; $display("FAIL rand_extra_port%0d: got beat %h want none", d, got);
                            end else begin
                                want = exp_q[d].pop_front();
                                if (got !== want) begin
                                    failed++; $display("FAIL rand_port%0d: got %h want %h", d, got, want);
                                end
                            end
                        end
                    end
                end
            end
        join
        for (int d = 0; d < 3; d++) begin
            b_rdy_i[d] = 1'b1;
            tests++; if (exp_q[d].size() != 0) begin
                failed++; $display("FAIL rand_missing_port%0d: got %0d beats undelivered want 0", d, exp_q[d].size());
            end
        end
        tests++; if (b_drop !== 2'((drops > 3) ? 3 : drops)) begin
            failed++; $display("FAIL rand_drop_cnt: got %0d want %0d", b_drop, (drops > 3) ? 3 : drops);
        end
    endtask

    initial begin
        a_dir = '0; a_data = '0; a_sop = 0; a_eop = 0; a_valid = 0; a_empty = '0; a_chan = 8'hA5;
        b_dir = '0; b_data = '0; b_sop = 0; b_eop = 0; b_valid = 0; b_empty = '0; b_chan = '0;
        for (int d = 0; d < 4; d++) a_rdy_i[d] = 1'b1;
        for (int d = 0; d < 3; d++) b_rdy_i[d] = 1'b1;
        rst_a_n = 1'b0; rst_b_n = 1'b0;
        @(negedge clk);
        test_reset();
        test_fwd_3beat();
        test_drop_mode1();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        test_drop_sat();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, failed);
        $fatal(1, "watchdog");
    end

endmodule
